// File: rtl/branch_resolve_unit_if.sv
// Bundle of EX-stage branch inputs and the predictor-training / redirect / flush
// outputs of branch_resolve_unit.
// The BRU_STATS_EN macro adds the stat_branches / stat_mispredicts counters.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic        ex_valid;
  logic        ex_is_branch;
  logic [1:0]  ex_br_type;
  logic [31:0] ex_pc;
  logic [15:0] ex_imm;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_pred_dir;

  logic        bp_is_branch;
  logic        bp_actual_result;
  logic [31:0] bp_bpc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_pipeline;
  logic        busy_flush;
`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;
`endif

  // Pipeline side: drives the EX operands, observes the resolution results.
  modport master (
    output ex_valid, ex_is_branch, ex_br_type, ex_pc, ex_imm,
           ex_rs_val, ex_rt_val, ex_pred_dir,
    input  bp_is_branch, bp_actual_result, bp_bpc, redirect_valid,
           redirect_pc, flush_pipeline, busy_flush
`ifdef BRU_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  // Branch resolve unit side.
  modport slave (
    input  ex_valid, ex_is_branch, ex_br_type, ex_pc, ex_imm,
           ex_rs_val, ex_rt_val, ex_pred_dir,
    output bp_is_branch, bp_actual_result, bp_bpc, redirect_valid,
           redirect_pc, flush_pipeline, busy_flush
`ifdef BRU_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution for the MIPS32 pipeline.
// Evaluates the branch condition, trains the 1-bit predictor, and on a
// mispredict issues a PC redirect plus a FLUSH_CYCLES-long IF/ID flush.
// Branches arriving while the flush is active are squashed.
// Optional feature: define BRU_STATS_EN for saturating branch/mispredict counters.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        bp_is_branch_q, bp_is_branch_d;
  logic        bp_actual_q, bp_actual_d;
  logic [31:0] bp_bpc_q, bp_bpc_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;
  logic        busy_q, busy_d;

  logic        cond;
  logic        accept;
  logic        mispredict;
  logic [31:0] seq_pc;
  logic [31:0] tgt_pc;
  logic [31:0] offset;

  // Branch condition on the forwarded operands; rt only matters for BEQ/BNE.
  always_comb begin
    cond = 1'b0;
    case (bus.ex_br_type)
      2'b00:   cond = (bus.ex_rs_val == bus.ex_rt_val);
      2'b01:   cond = (bus.ex_rs_val != bus.ex_rt_val);
      2'b10:   cond = ($signed(bus.ex_rs_val) <= 32'sd0);
      default: cond = ($signed(bus.ex_rs_val) > 32'sd0);
    endcase
  end

  // Fall-through and taken targets, plain modulo-2^32 wrap.
  always_comb begin
    offset = {{14{bus.ex_imm[15]}}, bus.ex_imm, 2'b00};
    seq_pc = bus.ex_pc + 32'd4;
    tgt_pc = seq_pc + offset;
  end

  // Only a branch seen while IDLE is resolved; anything during FLUSH is squashed.
  always_comb begin
    accept     = bus.ex_valid & bus.ex_is_branch & (state_q == IDLE);
    mispredict = accept & (cond != bus.ex_pred_dir);
  end

  // Flush FSM: a mispredict enters FLUSH with the down-counter preloaded.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Next values of the registered outputs; training info holds until next accept.
  always_comb begin
    bp_is_branch_d   = accept;
    bp_actual_d      = bp_actual_q;
    bp_bpc_d         = bp_bpc_q;
    redirect_valid_d = mispredict;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = (state_d == FLUSH);
    busy_d           = (state_d == FLUSH);
    if (accept) begin
      bp_actual_d = cond;
      bp_bpc_d    = bus.ex_pc;
    end
    if (mispredict) begin
      redirect_pc_d = cond ? tgt_pc : seq_pc;
    end
  end

  // State and output registers; reset abandons any flush immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= 3'd0;
      bp_is_branch_q   <= 1'b0;
      bp_actual_q      <= 1'b0;
      bp_bpc_q         <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bp_is_branch_q   <= bp_is_branch_d;
      bp_actual_q      <= bp_actual_d;
      bp_bpc_q         <= bp_bpc_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      busy_q           <= busy_d;
    end
  end

  assign bus.bp_is_branch     = bp_is_branch_q;
  assign bus.bp_actual_result = bp_actual_q;
  assign bus.bp_bpc           = bp_bpc_q;
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.flush_pipeline   = flush_q;
  assign bus.busy_flush       = busy_q;

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

  // Saturating event counters: they stick at all-ones rather than wrapping.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (accept && !(&stat_branches_q)) begin
      stat_branches_d = stat_branches_q + 1'b1;
    end
    if (mispredict && !(&stat_mispredicts_q)) begin
      stat_mispredicts_d = stat_mispredicts_q + 1'b1;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage branch resolution for the MIPS32 pipeline; sits directly downstream of the 1-bit predictor.
- Evaluates the branch condition on the carried prediction, computes the taken target, and detects mispredicts.
- Drives the predictor's training inputs (is_Branch, actual_result, BPC).
- Issues a PC redirect plus a multi-cycle pipeline flush to the fetch/decode stages.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_pipeline is held high after a mispredict (1..7); covers the IF and ID bubbles.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_branch  in  1  instruction in EX is a conditional branch
- ex_br_type  in  2  00 BEQ, 01 BNE, 10 BLEZ, 11 BGTZ
- ex_pc  in  32  PC of the instruction in EX
- ex_imm  in  16  branch offset field (word offset)
- ex_rs_val  in  32  forwarded rs operand
- ex_rt_val  in  32  forwarded rt operand
- ex_pred_dir  in  1  prediction made at fetch, carried down the pipe
- bp_is_branch  out  1  update strobe to the predictor
- bp_actual_result  out  1  resolved direction (1 = taken)
- bp_bpc  out  32  PC of the resolved branch
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into fetch
- redirect_pc  out  32  corrected fetch address
- flush_pipeline  out  1  squash IF/ID contents
- busy_flush  out  1  FSM is in the FLUSH state

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE; every output is 0, including bp_bpc and redirect_pc; counters are cleared. The flush window is abandoned immediately.
- Accept: accept = ex_valid & ex_is_branch & (state==IDLE). The state is evaluated in the cycle the inputs are sampled.
- Condition (combinational):
  - BEQ: rs==rt.
  - BNE: rs!=rt.
  - BLEZ: $signed(rs)<=0.
  - BGTZ: $signed(rs)>0.
  - rt is ignored for BLEZ and BGTZ.
- Targets, computed in 32-bit modulo arithmetic with wrap-around allowed and no exception:
  - seq = ex_pc + 4.
  - tgt = ex_pc + 4 + (sign_ext(ex_imm) << 2).
- Latency: all outputs are registered; inputs sampled at edge N appear after edge N+1.
- Accepted branch:
  - bp_is_branch=1 for exactly one cycle.
  - bp_actual_result=cond.
  - bp_bpc=ex_pc.
  - bp_bpc and bp_actual_result hold their values until the next accept.
- Mispredict (accept & cond!=ex_pred_dir):
  - redirect_valid=1 for one cycle.
  - redirect_pc = cond ? tgt : seq.
  - flush_pipeline rises in the same cycle; FSM moves IDLE->FLUSH.
- Correct prediction: no redirect and no flush; FSM stays in IDLE.
- FSM:
  - IDLE: waits for a mispredict.
  - FLUSH: a down-counter loaded with FLUSH_CYCLES-1; flush_pipeline=1 and busy_flush=1 while in FLUSH; returns to IDLE when the count reaches 0.
  - flush_pipeline is high for exactly FLUSH_CYCLES cycles.
- Branches presented during FLUSH are squashed: no bp update, no redirect. This includes a branch presented in the last FLUSH cycle.
- ex_valid=0 or ex_is_branch=0: no update; outputs idle except for held values.
- Non-branch instructions never affect the FSM.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined, the following outputs are added:
  - stat_branches [CNT_W]: count of accepted branches.
  - stat_mispredicts [CNT_W]: count of mispredicts.
  - Both saturate at all-ones, never wrap, and clear on reset.
- When undefined, the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- BEQ at pc=0x100, rs=rt=5, imm=0x0004, pred=1 -> next cycle bp_is_branch=1, actual=1, bp_bpc=0x100; no redirect; flush stays 0.
- BNE at pc=0x200, rs=rt=7, pred=1 (mispredict, not taken) -> redirect_valid pulse, redirect_pc=0x204; flush_pipeline high 2 cycles; busy_flush high 2 cycles.
- BGTZ at pc=0x300, rs=0x00000001, imm=0xFFFE, pred=0 -> actual=1, redirect_pc=0x2FC, flush for FLUSH_CYCLES.
- Mispredict followed by a second mispredicting branch in each of the next 2 cycles -> only the first produces bp/redirect; a third branch presented after the FLUSH state exits is accepted.
- rst asserted low mid-FLUSH (async, between edges) -> flush_pipeline, busy_flush and redirect_valid drop immediately, with no clock edge needed; after release, the first branch is accepted normally.
- BLEZ with rs=0x80000000 (negative), pc=0xFFFFFFFC, imm=0x0001 -> actual=1, redirect target wraps to 0x00000004 if pred=0; with BRU_STATS_EN, stat_branches and stat_mispredicts are each incremented by 1.
